goertzel_sequencer: RTL and testbench
=====================================

Name: goertzel_sequencer

Overview:
- Control FSM that drives the Goertzel floating-point datapath (iteration pipe q0 = coeff*q1 − q2 + x, power pipe q1² + q2² − q1·q2·coeff). Both pipes have fixed latency.
- Accepts samples over a valid/ready handshake and issues one iteration at a time, because of the q1 dependency.
- Counts N_SAMPLES per block, then snapshots/clears the q registers and launches the power computation.
- The power computation overlaps the next block's accumulation.

Parameters:
- N_SAMPLES, 520, samples per Goertzel block (≥2).
- ITER_LAT, 12, iteration pipe latency in clock cycles (≥1).
- POW_LAT, 20, power pipe latency in clock cycles (≥1).
- CNT_W, 10, width of sample_index (2^CNT_W ≥ N_SAMPLES).

Ports:
- clock  in  1  system clock (130 MHz).
- reset  in  1  asynchronous reset, active-high.
- enable  in  1  run request; low → stop after the current iteration.
- sample_valid  in  1  upstream sample available.
- sample_ready  out  1  sequencer accepts a sample this cycle.
- iter_start  out  1  pulse; datapath latches the sample and launches an iteration.
- q_update  out  1  pulse; datapath writes q0 and shifts q2←q1, q1←q0.
- q_clear  out  1  pulse; datapath zeroes q0/q1/q2.
- pow_start  out  1  pulse; datapath copies q1/q2 to tmp and launches the power pipe.
- pow_capture  out  1  pulse; datapath registers the power result.
- block_done  out  1  pulse, coincident with pow_capture.
- sample_index  out  CNT_W  index of the current/next sample within the block.
- block_count  out  16  completed blocks, wraps at 65535→0.
- busy  out  1  state ≠ IDLE or power pipe in flight.

Behaviour:
Reset:
- Clock is `clock`; reset is `reset`, asynchronous, active-high.
- While reset is high: state=IDLE, all outputs 0, sample_index=0, block_count=0, latency counters 0.
- Any in-flight iteration or power result is abandoned; no pulses fire after reset.

States: IDLE, CLEAR, WAIT, ITER, SNAP.
- IDLE: sample_ready=0. enable=1 → CLEAR.
- CLEAR (1 cycle): q_clear=1, sample_index←0 → WAIT.
- WAIT:
  - sample_ready = enable.
  - Accept on sample_valid & sample_ready (cycle t) → ITER.
  - enable=0 → IDLE; the partial block is discarded.
- ITER:
  - iter_start=1 at t+1 (first ITER cycle).
  - q_update=1 at t+1+ITER_LAT (last ITER cycle).
  - On the q_update cycle, choose next state:
    - sample_index = N_SAMPLES−1 → SNAP.
    - Otherwise, if enable=1: sample_index+1 → WAIT.
    - Otherwise → IDLE.
  - enable is ignored inside ITER until q_update; an iteration is never cut short.
  - Throughput: one sample per ITER_LAT+2 cycles.
- SNAP:
  - If the power pipe is busy, hold with sample_ready=0.
  - Otherwise, for one cycle: pow_start=1, q_clear=1, sample_index←0.
  - Then → WAIT if enable=1, else → IDLE.
  - pow_start and q_clear share the same cycle; the datapath copies tmp before clearing.

Power tracker (independent of the FSM):
- pow_start loads a down-counter with POW_LAT.
- pow_capture=1 and block_done=1 exactly POW_LAT cycles after pow_start, for one cycle.
- block_count increments on that same cycle.
- The power pipe counts as busy from the pow_start cycle through the pow_capture cycle inclusive.
- A new pow_start is allowed no earlier than the cycle after pow_capture.

Other rules:
- Pulses are single-cycle and registered; outputs have no combinational path from inputs, except sample_ready depends on enable.
- sample_valid held high while sample_ready=0 has no effect and is not lost; this is upstream's responsibility.
- Simultaneous events:
  - pow_capture of block k can coincide with any state of block k+1; the two are independent.
  - enable falling in SNAP still completes pow_start, then → IDLE.
  - The power result of the last completed block is always delivered even if enable=0.
- sample_index never exceeds N_SAMPLES−1.

Test Plan:
1. Reset: assert reset mid-ITER with ITER_LAT=3 → within the reset cycle all outputs 0, state IDLE. After release, no q_update or pow_capture appears within 10 cycles.
2. Block timing (N_SAMPLES=4, ITER_LAT=3, POW_LAT=5), enable=1, sample_valid=1 constant:
   - Expect q_clear at cycle 1.
   - Samples accepted at cycles 2, 7, 12, 17; iter_start at 3, 8, 13, 18; q_update at 6, 11, 16, 21.
   - pow_start + q_clear at 22; pow_capture/block_done at 27; block_count=1.
3. Overlap, same parameters: the second block's samples are accepted at 23, 28, … while the first power computation runs. pow_capture at 27 occurs while state=ITER, with no stall.
4. Stall: POW_LAT=30, N_SAMPLES=2, ITER_LAT=1:
   - The second block reaches SNAP before the first pow_capture and holds sample_ready=0.
   - The second pow_start occurs exactly 1 cycle after the first pow_capture.
5. Abort: deassert enable during ITER of sample 2 (N_SAMPLES=4) → q_update still fires, then IDLE. No pow_start, block_count unchanged. Re-enable → q_clear and sample_index=0.
6. Backpressure: sample_valid toggling 1/0 randomly for 3 blocks → exactly N_SAMPLES iter_start pulses per block_done. sample_index wraps 3→0 at each SNAP.

Source files
------------

// File: rtl/goertzel_sequencer_if.sv
// Sample handshake and datapath command strobes between the Goertzel sequencer
// and its surroundings; the sequencer is the master.
interface goertzel_sequencer_if;
  // sample_valid/sample_ready: a sample transfers on any cycle where both are high;
  // upstream keeps sample_valid asserted until that happens.
  logic sample_valid;
  logic sample_ready;
  logic iter_start;
  logic q_update;
  logic q_clear;
  logic pow_start;
  logic pow_capture;
  logic block_done;

  modport master (
    input  sample_valid,
    output sample_ready, iter_start, q_update, q_clear,
           pow_start, pow_capture, block_done
  );

  modport slave (
    output sample_valid,
    input  sample_ready, iter_start, q_update, q_clear,
           pow_start, pow_capture, block_done
  );
endinterface

// File: rtl/goertzel_sequencer.sv
// Control FSM for a Goertzel datapath: one iteration in flight at a time, block
// snapshot into a power pipe that overlaps accumulation of the next block.
module goertzel_sequencer #(
  parameter int N_SAMPLES = 520,
  parameter int ITER_LAT  = 12,
  parameter int POW_LAT   = 20,
  parameter int CNT_W     = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  goertzel_sequencer_if.master seq,
  output logic [CNT_W-1:0]     sample_index,
  output logic [15:0]          block_count,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int IT_W = $clog2(ITER_LAT + 1);
  localparam int PW_W = $clog2(POW_LAT + 1);
  localparam logic [IT_W-1:0]  ITER_PRE  = IT_W'(ITER_LAT - 1);
  localparam logic [IT_W-1:0]  ITER_LAST = IT_W'(ITER_LAT);
  localparam logic [CNT_W-1:0] IDX_LAST  = CNT_W'(N_SAMPLES - 1);
  localparam logic [PW_W-1:0]  POW_LOAD  = PW_W'(POW_LAT);
  localparam logic [PW_W-1:0]  POW_ONE   = PW_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WAIT  = 3'd2,
    S_ITER  = 3'd3,
    S_SNAP  = 3'd4
  } state_t;

  state_t          state;
  logic [IT_W-1:0] iter_cnt;
  logic [PW_W-1:0] pow_cnt;
  logic            iter_start_r;
  logic            q_update_r;
  logic            q_clear_r;
  logic            pow_start_r;
  logic            pow_capture_r;

  logic accept;
  logic snap_req;
  logic fire;

  assign seq.sample_ready = (state == S_WAIT) && enable;
  assign accept           = seq.sample_ready && seq.sample_valid;

  // A block snapshot is wanted on the last q_update of a block, or while parked
  // in SNAP before the pulse went out; it fires only once the power pipe has
  // delivered (pow_cnt is zero on and after the pow_capture cycle).
  assign snap_req = ((state == S_ITER) && (iter_cnt == ITER_LAST) && (sample_index == IDX_LAST))
                 || ((state == S_SNAP) && !pow_start_r);
  assign fire     = snap_req && (pow_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      iter_cnt     <= '0;
      sample_index <= '0;
      iter_start_r <= 1'b0;
      q_update_r   <= 1'b0;
      q_clear_r    <= 1'b0;
      pow_start_r  <= 1'b0;
    end else begin
      iter_start_r <= 1'b0;
      q_update_r   <= 1'b0;
      q_clear_r    <= 1'b0;
      pow_start_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state        <= S_CLEAR;
            q_clear_r    <= 1'b1;
            sample_index <= '0;
          end
        end
        S_CLEAR: state <= S_WAIT;
        S_WAIT: begin
          if (accept) begin
            state        <= S_ITER;
            iter_start_r <= 1'b1;
            iter_cnt     <= '0;
          end else if (!enable) begin
            state <= S_IDLE;
          end
        end
        S_ITER: begin
          iter_cnt <= iter_cnt + IT_W'(1);
          if (iter_cnt == ITER_PRE) q_update_r <= 1'b1;
          if (iter_cnt == ITER_LAST) begin
            if (sample_index == IDX_LAST) begin
              state <= S_SNAP;
              if (fire) begin
                pow_start_r  <= 1'b1;
                q_clear_r    <= 1'b1;
                sample_index <= '0;
              end
            end else if (enable) begin
              state        <= S_WAIT;
              sample_index <= sample_index + CNT_W'(1);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_SNAP: begin
          if (pow_start_r) begin
            state <= enable ? S_WAIT : S_IDLE;
          end else if (fire) begin
            pow_start_r  <= 1'b1;
            q_clear_r    <= 1'b1;
            sample_index <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Power tracker: pow_cnt holds POW_LAT on the pow_start cycle and reaches
  // zero on the pow_capture cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pow_cnt       <= '0;
      pow_capture_r <= 1'b0;
      block_count   <= '0;
    end else begin
      pow_capture_r <= (pow_cnt == POW_ONE);
      if (pow_cnt == POW_ONE) block_count <= block_count + 16'd1;
      if (fire) begin
        pow_cnt <= POW_LOAD;
      end else if (pow_cnt != '0) begin
        pow_cnt <= pow_cnt - POW_ONE;
      end
    end
  end

  assign seq.iter_start  = iter_start_r;
  assign seq.q_update    = q_update_r;
  assign seq.q_clear     = q_clear_r;
  assign seq.pow_start   = pow_start_r;
  assign seq.pow_capture = pow_capture_r;
  assign seq.block_done  = pow_capture_r;

  assign busy      = (state != S_IDLE) || (pow_cnt != '0) || pow_capture_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_goertzel_sequencer.sv
// Directed bench for goertzel_sequencer: event cycles logged per DUT and
// compared against hand-derived cycle lists.
module tb_goertzel_sequencer;

  localparam int ST_IDLE = 0;
  localparam int ST_ITER = 3;
  localparam int ST_SNAP = 4;
  localparam int SNAP_N  = 2048;

  logic clock = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic en_a  = 1'b0;
  logic en_b  = 1'b0;

  logic [2:0]  idx_a;
  logic [1:0]  idx_b;
  logic [15:0] bc_a, bc_b;
  logic        busy_a, busy_b;
  logic [2:0]  st_a, st_b;

  goertzel_sequencer_if if_a ();
  goertzel_sequencer_if if_b ();

  goertzel_sequencer #(.N_SAMPLES(4), .ITER_LAT(3), .POW_LAT(5), .CNT_W(3)) dut_a (
    .clock(clock), .reset(rst_a), .enable(en_a), .seq(if_a),
    .sample_index(idx_a), .block_count(bc_a), .busy(busy_a), .state_dbg(st_a)
  );

  goertzel_sequencer #(.N_SAMPLES(2), .ITER_LAT(1), .POW_LAT(30), .CNT_W(2)) dut_b (
    .clock(clock), .reset(rst_b), .enable(en_b), .seq(if_b),
    .sample_index(idx_b), .block_count(bc_b), .busy(busy_b), .state_dbg(st_b)
  );

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // event monitors, sampled mid-cycle
  logic mon_a = 1'b0;
  logic mon_b = 1'b0;
  logic [31:0] a_qclr[$], a_acc[$], a_iter[$], a_qupd[$], a_pst[$], a_pcap[$], a_bdone[$];
  logic [31:0] b_acc[$], b_pst[$], b_pcap[$];
  int a_st[SNAP_N], a_idx[SNAP_N], a_bc[SNAP_N], a_rdy[SNAP_N];
  int b_st[SNAP_N], b_idx[SNAP_N], b_bc[SNAP_N], b_rdy[SNAP_N];

  always @(negedge clock) begin
    if (mon_a && cyc < SNAP_N) begin
      if (if_a.q_clear)                          a_qclr.push_back(cyc);
      if (if_a.sample_valid && if_a.sample_ready) a_acc.push_back(cyc);
      if (if_a.iter_start)                       a_iter.push_back(cyc);
      if (if_a.q_update)                         a_qupd.push_back(cyc);
      if (if_a.pow_start)                        a_pst.push_back(cyc);
      if (if_a.pow_capture)                      a_pcap.push_back(cyc);
      if (if_a.block_done)                       a_bdone.push_back(cyc);
      a_st[cyc]  = int'(st_a);
      a_idx[cyc] = int'(idx_a);
      a_bc[cyc]  = int'(bc_a);
      a_rdy[cyc] = int'(if_a.sample_ready);
    end
    if (mon_b && cyc < SNAP_N) begin
      if (if_b.sample_valid && if_b.sample_ready) b_acc.push_back(cyc);
      if (if_b.pow_start)                        b_pst.push_back(cyc);
      if (if_b.pow_capture)                      b_pcap.push_back(cyc);
      b_st[cyc]  = int'(st_b);
      b_idx[cyc] = int'(idx_b);
      b_bc[cyc]  = int'(bc_b);
      b_rdy[cyc] = int'(if_b.sample_ready);
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_list(input string tag, input logic [31:0] got[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
  endtask

  // driver tasks
  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic clear_logs();
    a_qclr.delete(); a_acc.delete(); a_iter.delete(); a_qupd.delete();
    a_pst.delete(); a_pcap.delete(); a_bdone.delete();
    b_acc.delete(); b_pst.delete(); b_pcap.delete();
  endtask

  // Leaves the caller at cycle 0 with enable just raised.
  task automatic start_a(input logic valid);
    rst_a = 1'b1; en_a = 1'b0; if_a.sample_valid = 1'b0;
    @(posedge clock); #2;
    rst_a = 1'b0;
    @(posedge clock); #2;
    clear_logs();
    cyc = 0; mon_a = 1'b1;
    en_a = 1'b1; if_a.sample_valid = valid;
  endtask

  task automatic start_b();
    rst_b = 1'b1; en_b = 1'b0; if_b.sample_valid = 1'b0;
    @(posedge clock); #2;
    rst_b = 1'b0;
    @(posedge clock); #2;
    clear_logs();
    cyc = 0; mon_b = 1'b1;
    en_b = 1'b1; if_b.sample_valid = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int prev;
    int n;
    if_a.sample_valid = 1'b0;
    if_b.sample_valid = 1'b0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // block timing and overlap: N=4, ITER_LAT=3, POW_LAT=5, valid always high
    start_a(1'b1);
    to_cycle(46);
    mon_a = 1'b0;
    exp_q = '{1, 22, 43};                          check_list("blk_q_clear", a_qclr);
    exp_q = '{2, 7, 12, 17, 23, 28, 33, 38, 44};   check_list("blk_accept", a_acc);
    exp_q = '{3, 8, 13, 18, 24, 29, 34, 39, 45};   check_list("blk_iter_start", a_iter);
    exp_q = '{6, 11, 16, 21, 27, 32, 37, 42};      check_list("blk_q_update", a_qupd);
    exp_q = '{22, 43};                             check_list("blk_pow_start", a_pst);
    exp_q = '{27};                                 check_list("blk_pow_capture", a_pcap);
    check_list("blk_block_done", a_bdone);
    check("blk_state_at_capture", 32'(a_st[27]), ST_ITER);
    check("blk_count_before", 32'(a_bc[26]), 0);
    check("blk_count_after", 32'(a_bc[28]), 1);
    check("blk_index_last", 32'(a_idx[21]), 3);
    check("blk_index_wrap", 32'(a_idx[22]), 0);
    check("blk_ready_in_snap", 32'(a_rdy[22]), 0);

    // reset mid-ITER with a power result still in flight
    check("rst_pre_state", 32'(st_a), ST_ITER);
    check("rst_pre_busy", 32'(busy_a), 1);
    rst_a = 1'b1; en_a = 1'b0;
    #1;
    check("rst_pulses", 32'({if_a.sample_ready, if_a.iter_start, if_a.q_update, if_a.q_clear,
                             if_a.pow_start, if_a.pow_capture, if_a.block_done}), 0);
    check("rst_state", 32'(st_a), ST_IDLE);
    check("rst_index", 32'(idx_a), 0);
    check("rst_block_count", 32'(bc_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    @(posedge clock); #2;
    rst_a = 1'b0;
    clear_logs();
    cyc = 0; mon_a = 1'b1;
    to_cycle(12);
    mon_a = 1'b0;
    check("rst_after_q_update", 32'(a_qupd.size()), 0);
    check("rst_after_pow_capture", 32'(a_pcap.size()), 0);
    check("rst_after_pow_start", 32'(a_pst.size()), 0);
    check("rst_after_state", 32'(a_st[11]), ST_IDLE);

    // abort: enable drops during the second sample's iteration
    start_a(1'b1);
    to_cycle(9);
    en_a = 1'b0;
    to_cycle(15);
    en_a = 1'b1;
    to_cycle(25);
    mon_a = 1'b0;
    exp_q = '{1, 16};          check_list("abt_q_clear", a_qclr);
    exp_q = '{2, 7, 17, 22};   check_list("abt_accept", a_acc);
    exp_q = '{6, 11, 21};      check_list("abt_q_update", a_qupd);
    exp_q.delete();            check_list("abt_pow_start", a_pst);
    check("abt_state_idle", 32'(a_st[12]), ST_IDLE);
    check("abt_index_held", 32'(a_idx[14]), 1);
    check("abt_index_clear", 32'(a_idx[16]), 0);
    check("abt_block_count", 32'(a_bc[24]), 0);
    rst_a = 1'b1; en_a = 1'b0; if_a.sample_valid = 1'b0;

    // stall: N=2, ITER_LAT=1, POW_LAT=30 -- second block waits in SNAP
    start_b();
    to_cycle(46);
    mon_b = 1'b0;
    exp_q = '{2, 5, 9, 12, 40, 43}; check_list("stl_accept", b_acc);
    exp_q = '{8, 39};               check_list("stl_pow_start", b_pst);
    exp_q = '{38};                  check_list("stl_pow_capture", b_pcap);
    check("stl_state_snap", 32'(b_st[20]), ST_SNAP);
    check("stl_ready_low", 32'(b_rdy[20]), 0);
    check("stl_index_held", 32'(b_idx[20]), 1);
    check("stl_count_before", 32'(b_bc[37]), 0);
    check("stl_count_after", 32'(b_bc[45]), 1);
    rst_b = 1'b1; en_b = 1'b0; if_b.sample_valid = 1'b0;

    // backpressure: random sample_valid over three blocks
    start_a(1'b0);
    while (a_bdone.size() < 3 && cyc < 1500) begin
      if_a.sample_valid = 1'($urandom_range(0, 1));
      @(posedge clock); #2;
    end
    mon_a = 1'b0;
    check("bp_blocks_done", 32'(a_bdone.size()), 3);
    check("bp_pow_starts", 32'(a_pst.size() >= 3), 1);
    prev = -1;
    for (int k = 0; k < 3 && k < a_pst.size(); k++) begin
      n = 0;
      foreach (a_iter[j])
        if (int'(a_iter[j]) > prev && a_iter[j] < a_pst[k]) n++;
      check($sformatf("bp_iters_blk%0d", k), 32'(n), 4);
      check($sformatf("bp_index_pre%0d", k), 32'(a_idx[a_pst[k] - 1]), 3);
      check($sformatf("bp_index_wrap%0d", k), 32'(a_idx[a_pst[k]]), 0);
      prev = int'(a_pst[k]);
    end
    if (a_bdone.size() >= 3)
      check("bp_block_count", 32'(a_bc[a_bdone[2]]), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
